// File: rtl/param_register_file_if.sv
// ---------------------------------------------------------------------------
// param_register_file_if
//   Bundles the write port, the two read ports, the clear request and the
//   busy status of param_register_file.
//
//   Handshake: there is no valid/ready pair. busy acts as an inverted ready
//   for the command inputs (we, clr). While busy=1, every write and every clr
//   is dropped, not queued. While busy=0, a command is accepted on the rising
//   clock edge where it is present. Reads are combinational and are not
//   affected by busy.
//
//   Signals (direction seen from the register file, i.e. the slave):
//     we       in   write enable
//     W_Adr    in   write address
//     W        in   write data
//     R_Adr    in   read port R address
//     S_Adr    in   read port S address
//     clr      in   start a clear sweep
//     R, S     out  entry data at R_Adr / S_Adr
//     R_valid  out  valid bit of the entry at R_Adr
//     S_valid  out  valid bit of the entry at S_Adr
//     busy     out  clear sweep in progress
// ---------------------------------------------------------------------------
interface param_register_file_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              we;
   logic [ADDR_W-1:0] W_Adr;
   logic [DATA_W-1:0] W;
   logic [ADDR_W-1:0] R_Adr;
   logic [ADDR_W-1:0] S_Adr;
   logic              clr;
   logic [DATA_W-1:0] R;
   logic [DATA_W-1:0] S;
   logic              R_valid;
   logic              S_valid;
   logic              busy;

   modport master (
      output we, W_Adr, W, R_Adr, S_Adr, clr,
      input  R, S, R_valid, S_valid, busy
   );

   modport slave (
      input  we, W_Adr, W, R_Adr, S_Adr, clr,
      output R, S, R_valid, S_valid, busy
   );
endinterface

// File: rtl/param_register_file.sv
// ---------------------------------------------------------------------------
// param_register_file
//   Register file with one write port and two combinational read ports
//   (R, S). Each entry has a valid bit. A clr request starts a sweep that
//   zeroes one entry per cycle, and busy is high for the sweep.
//
//   Parameters:
//     DATA_W  data width of each entry
//     DEPTH   number of entries, must equal 2**ADDR_W
//     ADDR_W  address width
//
//   Ports:
//     clk          system clock, rising edge
//     reset        synchronous, active-high reset. It wins over every input
//                  and aborts a running sweep.
//     bus          param_register_file_if.slave (write/read/clear/busy)
//     dbg_state_o  current FSM state (0 = IDLE, 1 = CLEAR)
//
//   Configuration macro:
//     REGFILE_ZERO_REG_EN  when defined, entry 0 is hardwired. Reads of
//                          address 0 return 0 with valid=1, and writes to
//                          address 0 are dropped.
// ---------------------------------------------------------------------------
module param_register_file #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   param_register_file_if.slave  bus,
   output logic                  dbg_state_o
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;
   logic              busy_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic              wr_allow;

`ifdef REGFILE_ZERO_REG_EN
   assign wr_allow = (bus.W_Adr != '0);
`else
   assign wr_allow = 1'b1;
`endif

   assign ptr_d = ptr_q + ADDR_W'(1);

   // The write only happens in IDLE, and only when no clr is present in the
   // same cycle, so a write and a clear never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         valid_q <= '0;
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.clr) begin
                  state_q <= ST_CLEAR;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end else if (bus.we && wr_allow) begin
                  mem_q[bus.W_Adr]   <= bus.W;
                  valid_q[bus.W_Adr] <= 1'b1;
               end
            end
            ST_CLEAR: begin
               mem_q[ptr_q]   <= '0;
               valid_q[ptr_q] <= 1'b0;
               ptr_q          <= ptr_d;
               // The last entry is cleared in this cycle, so busy drops on
               // the same edge. busy is then high for exactly DEPTH cycles.
               if (ptr_q == LAST_PTR) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Reads come straight from the array. There is no write bypass, so a read
   // of W_Adr in the write cycle returns the old contents.
`ifdef REGFILE_ZERO_REG_EN
   assign bus.R       = (bus.R_Adr == '0) ? '0 : mem_q[bus.R_Adr];
   assign bus.S       = (bus.S_Adr == '0) ? '0 : mem_q[bus.S_Adr];
   assign bus.R_valid = (bus.R_Adr == '0) | valid_q[bus.R_Adr];
   assign bus.S_valid = (bus.S_Adr == '0) | valid_q[bus.S_Adr];
`else
   assign bus.R       = mem_q[bus.R_Adr];
   assign bus.S       = mem_q[bus.S_Adr];
   assign bus.R_valid = valid_q[bus.R_Adr];
   assign bus.S_valid = valid_q[bus.S_Adr];
`endif

   assign bus.busy    = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_param_register_file.sv
// ---------------------------------------------------------------------------
// tb_param_register_file
//   Testbench for param_register_file. Directed scenarios are followed by
//   random traffic. For each driven cycle, the expected
//   {busy, S_valid, R_valid, S, R} comes from an array model and is queued.
//   A monitor on the falling edge pops each entry and compares it with the
//   DUT outputs.
// ---------------------------------------------------------------------------
module tb_param_register_file;

   localparam int DW  = 16;
   localparam int AW  = 3;
   localparam int DEP = 8;
   localparam int EW  = 2 * DW + 3;

`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic dbg_state;
   always #5 clk = ~clk;

   param_register_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   param_register_file #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   // ---------------- reference model ----------------
   logic [DW-1:0] m_mem   [DEP];
   bit            m_valid [DEP];
   int            sweep_left;   // remaining cycles of a running clear sweep

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q [$];
   string         tag_q [$];
   int            errors = 0;
   int            checks = 0;
   string         cur_tag = "init";

   function automatic logic [EW-1:0] model_read(input logic [AW-1:0] ra,
                                                input logic [AW-1:0] sa);
      logic [DW-1:0] r, s;
      logic          rv, sv, b;
      if (ZR && ra == 0) begin r = '0; rv = 1'b1; end
      else begin r = m_mem[ra]; rv = m_valid[ra]; end
      if (ZR && sa == 0) begin s = '0; sv = 1'b1; end
      else begin s = m_mem[sa]; sv = m_valid[sa]; end
      b = (sweep_left != 0);
      return {b, sv, rv, s, r};
   endfunction

   // One clock edge of the model, applied with the inputs that were present.
   task automatic model_edge(input bit rst, input bit we, input bit clr,
                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      if (rst) begin
         for (int i = 0; i < DEP; i++) begin m_mem[i] = '0; m_valid[i] = 0; end
         sweep_left = 0;
      end else if (sweep_left > 0) begin
         m_mem[DEP - sweep_left]   = '0;
         m_valid[DEP - sweep_left] = 0;
         sweep_left--;
      end else if (clr) begin
         sweep_left = DEP;
      end else if (we && !(ZR && wa == 0)) begin
         m_mem[wa]   = wd;
         m_valid[wa] = 1;
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit rst, input bit we, input bit clr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] sa,
                       input bit chk);
      reset     = rst;
      bus.we    = we;
      bus.clr   = clr;
      bus.W_Adr = wa;
      bus.W     = wd;
      bus.R_Adr = ra;
      bus.S_Adr = sa;
      if (chk) begin
         exp_q.push_back(model_read(ra, sa));
         tag_q.push_back(cur_tag);
      end
      @(posedge clk);
      model_edge(rst, we, clr, wa, wd);
      #1;
   endtask

   task automatic idle_read(input logic [AW-1:0] ra, input logic [AW-1:0] sa);
      step(0, 0, 0, '0, '0, ra, sa, 1);
   endtask

   task automatic rnd_read();
      idle_read(AW'($urandom_range(0, DEP-1)), AW'($urandom_range(0, DEP-1)));
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [EW-1:0] e, a;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {bus.busy, bus.S_valid, bus.R_valid, bus.S, bus.R};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t: got busy=%b Sv=%b Rv=%b S=%h R=%h, expected busy=%b Sv=%b Rv=%b S=%h R=%h",
                     t, $time, a[EW-1], a[EW-2], a[EW-3], a[2*DW-1:DW], a[DW-1:0],
                     e[EW-1], e[EW-2], e[EW-3], e[2*DW-1:DW], e[DW-1:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      sweep_left = 0;
      for (int i = 0; i < DEP; i++) begin m_mem[i] = 'x; m_valid[i] = 0; end

      // 1: reset, then read every entry
      cur_tag = "reset";
      step(1, 0, 0, '0, '0, '0, '0, 0);
      for (int k = 0; k < 4; k++) idle_read(AW'(k), AW'(k + 4));

      // 2: write ~k to entry k. R reads W_Adr in the same cycle (old value).
      cur_tag = "write_same_cycle";
      for (int k = 0; k < DEP; k++)
         step(0, 1, 0, AW'(k), ~DW'(k), AW'(k), AW'($urandom_range(0, DEP-1)), 1);
      cur_tag = "read_back";
      for (int k = 0; k < 4; k++) idle_read(AW'(k), AW'(k + 4));

      // 3: clear sweep, with writes to entry 2 attempted while busy
      cur_tag = "clr_pulse";
      step(0, 0, 1, '0, '0, 3'd2, 3'd7, 1);
      cur_tag = "sweep_busy";
      for (int c = 0; c < DEP + 2; c++)
         step(0, 1, 0, 3'd2, 16'h1234, AW'($urandom_range(0, DEP-1)), 3'd2, 1);
      cur_tag = "after_sweep";
      for (int k = 0; k < 4; k++) idle_read(AW'(k), AW'(k + 4));

      // 4: clr and we in the same cycle, so clr wins
      cur_tag = "clr_vs_we";
      step(0, 1, 0, 3'd1, 16'h5A5A, 3'd1, 3'd5, 1);
      step(0, 1, 1, 3'd5, 16'hBEEF, 3'd5, 3'd1, 1);
      for (int c = 0; c < DEP + 1; c++) idle_read(3'd5, 3'd1);

      // 5: reset three cycles into a sweep
      cur_tag = "reset_mid_sweep";
      for (int k = 0; k < DEP; k++)
         step(0, 1, 0, AW'(k), DW'($urandom), AW'(k), AW'(7 - k), 1);
      step(0, 0, 1, '0, '0, 3'd0, 3'd4, 1);
      for (int c = 0; c < 3; c++) idle_read(AW'(c), AW'(c + 4));
      step(1, 0, 0, '0, '0, 3'd6, 3'd7, 1);
      for (int k = 0; k < 4; k++) idle_read(AW'(k), AW'(k + 4));

      // 6: write to address 0 (hardwired only with the zero-register macro)
      cur_tag = "addr0_write";
      step(0, 1, 0, 3'd0, 16'hAAAA, 3'd0, 3'd0, 1);
      idle_read(3'd0, 3'd0);

      // 7: random traffic
      cur_tag = "random";
      for (int n = 0; n < 300; n++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 24) == 0,
              AW'($urandom_range(0, DEP-1)), DW'($urandom),
              AW'($urandom_range(0, DEP-1)), AW'($urandom_range(0, DEP-1)), 1);
      end
      cur_tag = "final_reads";
      for (int n = 0; n < 4; n++) rnd_read();

      // Drain the scoreboard, with a bounded wait.
      for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
